trap_controller: RTL
====================

# trap_controller

Machine-mode trap sequencer in the execute stage. It accepts exception reports from the execute units (ECALL/EBREAK/illegal, etc.), pending interrupts, MRET and WFI. It serialises the resulting MEPC/MCAUSE/MTVAL updates over the single shared CSR write port, then issues one PC redirect to the trap vector or to MEPC. While a trap is in flight it stalls and flushes the pipeline, and during WFI it holds the pipeline until an interrupt is pending.

## Interface
Parameters:
- XLEN, 32, data/address width
- CAUSE_W, 6, exception/interrupt cause width (matches exception_num buses)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- exc_valid  in  1  exception reported by execute (exception_valid_out OR-tree)
- exc_num  in  CAUSE_W  exception cause (11 = ECALL_M, 3 = EBREAK)
- exc_pc  in  XLEN  PC of faulting instruction
- exc_tval  in  XLEN  trap value (0 for ECALL/EBREAK)
- irq_pending  in  1  interrupt pending (mip & mie, any)
- irq_enable  in  1  mstatus.MIE
- irq_cause  in  CAUSE_W  highest-priority pending interrupt cause
- irq_pc  in  XLEN  PC of next unexecuted instruction
- mret_valid  in  1  MRET executing
- wfi_valid  in  1  WFI executing
- wfi_pc  in  XLEN  PC of the WFI
- mtvec  in  XLEN  current mtvec CSR value
- mepc  in  XLEN  current mepc CSR value
- req_ready  out  1  controller idle; requests accepted this cycle
- stall  out  1  hold fetch/decode/execute
- flush  out  1  one-cycle pulse; kill younger instructions
- csr_wr_valid  out  1  CSR write request
- csr_wr_ready  in  1  CSR file accepts write this cycle
- csr_wr_addr  out  12  CSR address
- csr_wr_data  out  XLEN  CSR write data
- redirect_valid  out  1  one-cycle pulse; load redirect_pc into PC
- redirect_pc  out  XLEN  redirect target

## Operation
- States: IDLE, WR_EPC, WR_CAUSE, WR_TVAL, REDIRECT, WFI_WAIT.
- req_ready = (state == IDLE), combinational. Inputs are sampled only in IDLE.
- IDLE priority, highest first:
  - exc_valid → capture epc = exc_pc, cause = {0, exc_num} (bit XLEN-1 clear), tval = exc_tval, is_irq = 0 → WR_EPC.
  - irq_pending & irq_enable → capture epc = irq_pc, cause = {1, irq_cause} (bit XLEN-1 set), tval = 0, is_irq = 1 → WR_EPC.
  - mret_valid → latch target = mepc → REDIRECT.
  - wfi_valid → WFI_WAIT.
- WR_EPC / WR_CAUSE / WR_TVAL:
  - Drive csr_wr_valid with addr 0x341 / 0x342 / 0x343 and the captured epc / cause / tval.
  - Advance only on the cycle csr_wr_valid & csr_wr_ready. Addr/data are held stable while waiting.
- Trap target is computed at capture:
  - base = {mtvec[XLEN-1:2], 2'b00}.
  - If mtvec[1:0] == 1 and is_irq: target = base + (irq_cause << 2), truncated to XLEN (wraps).
  - Otherwise: target = base. mtvec[1:0] = 2 or 3 is treated as direct.
- REDIRECT: redirect_valid = 1, redirect_pc = target, for exactly one cycle → IDLE.
- WFI_WAIT:
  - Exit when irq_pending, regardless of irq_enable.
  - irq_enable = 1 → capture epc = wfi_pc + 4, cause/tval as for an interrupt → WR_EPC.
  - irq_enable = 0 → IDLE, no redirect; execution resumes after the WFI.
  - An exc_valid or mret_valid arriving in WFI_WAIT is ignored; the pipeline is stalled.
- stall = (state != IDLE).
- flush pulses for one cycle on the edge leaving IDLE for WR_EPC or REDIRECT. It does not pulse for WFI entry.
- MRET does not write CSRs; the mstatus MIE/MPIE swap belongs to the CSR file.

## Timing
- Reset (async, reset_n low):
  - state = IDLE.
  - Captured registers = 0.
  - stall, flush, csr_wr_valid, redirect_valid = 0; csr_wr_addr = 0; csr_wr_data = 0; redirect_pc = 0.
  - req_ready = 1 after reset deassertion.
- Reset mid-sequence aborts immediately; a partial CSR write sequence is not resumed.
- Exception accepted at edge T, with csr_wr_ready tied high:
  - T+1: flush = 1, csr EPC write.
  - T+2: CAUSE write.
  - T+3: TVAL write.
  - T+4: redirect_valid.
  - T+5: IDLE, req_ready = 1.
  - Minimum 4-cycle occupancy. Each cycle csr_wr_ready is low adds one cycle.
- MRET accepted at T: T+1 flush and redirect_valid with redirect_pc = mepc sampled at T. T+2 IDLE.
- WFI accepted at T: stall from T+1. irq_pending seen at edge E → next state at E+1.
- All outputs registered or decoded from state/captured registers; no combinational path from inputs to outputs.

## Test plan
- ECALL: exc_valid, exc_num = 11, exc_pc = 0x100, exc_tval = 0, mtvec = 0x8000_0000, csr_wr_ready = 1 → writes (0x341, 0x100), (0x342, 0x0000_000B), (0x343, 0) on consecutive cycles, then redirect_pc = 0x8000_0000. stall high for 4 cycles; flush exactly once.
- CSR backpressure: EBREAK with csr_wr_ready low 3 cycles during the MCAUSE write → addr 0x342 / data 0x3 held stable, redirect delayed 3 cycles, no duplicate writes.
- Vectored interrupt: irq_pending, irq_enable, irq_cause = 7, irq_pc = 0x200, mtvec = 0x8000_0001 → mcause = 0x8000_0007, mepc = 0x200, redirect_pc = 0x8000_001C.
- Priority: exc_valid, irq_pending & irq_enable, mret_valid all set in one IDLE cycle → exception sequence only. mret_valid alone afterwards with mepc = 0x400 → single-cycle redirect to 0x400, no CSR writes.
- WFI: wfi_valid, wfi_pc = 0x300, irq_pending low 10 cycles → stall held 10 cycles. Then irq_pending with irq_enable = 0 → IDLE, no redirect. Repeat with irq_enable = 1 → mepc = 0x304 trap.
- Reset mid-trap: reset_n low during WR_CAUSE → all outputs 0 immediately. After release, req_ready = 1 and no pending redirect.

Source files
------------

// File: rtl/trap_controller_if.sv
// Signal bundle between the trap controller, the execute stage and the CSR write port.
// The master modport is the controller's side, the slave modport is the surrounding pipeline.
interface trap_controller_if #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 6
);
  logic               exc_valid;
  logic [CAUSE_W-1:0] exc_num;
  logic [XLEN-1:0]    exc_pc;
  logic [XLEN-1:0]    exc_tval;
  logic               irq_pending;
  logic               irq_enable;
  logic [CAUSE_W-1:0] irq_cause;
  logic [XLEN-1:0]    irq_pc;
  logic               mret_valid;
  logic               wfi_valid;
  logic [XLEN-1:0]    wfi_pc;
  logic [XLEN-1:0]    mtvec;
  logic [XLEN-1:0]    mepc;
  logic               req_ready;
  logic               stall;
  logic               flush;
  logic               csr_wr_valid;
  logic               csr_wr_ready;
  logic [11:0]        csr_wr_addr;
  logic [XLEN-1:0]    csr_wr_data;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;

  modport master (
    input  exc_valid, exc_num, exc_pc, exc_tval,
    input  irq_pending, irq_enable, irq_cause, irq_pc,
    input  mret_valid, wfi_valid, wfi_pc, mtvec, mepc,
    input  csr_wr_ready,
    output req_ready, stall, flush,
    output csr_wr_valid, csr_wr_addr, csr_wr_data,
    output redirect_valid, redirect_pc
  );

  modport slave (
    output exc_valid, exc_num, exc_pc, exc_tval,
    output irq_pending, irq_enable, irq_cause, irq_pc,
    output mret_valid, wfi_valid, wfi_pc, mtvec, mepc,
    output csr_wr_ready,
    input  req_ready, stall, flush,
    input  csr_wr_valid, csr_wr_addr, csr_wr_data,
    input  redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: serialises MEPC/MCAUSE/MTVAL writes over one CSR port,
// then issues a single PC redirect; also handles MRET and WFI.
module trap_controller #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  trap_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_EPC   = 3'd1,
    S_WR_CAUSE = 3'd2,
    S_WR_TVAL  = 3'd3,
    S_REDIRECT = 3'd4,
    S_WFI_WAIT = 3'd5
  } state_t;

  localparam logic [11:0]     CSR_MEPC   = 12'h341;
  localparam logic [11:0]     CSR_MCAUSE = 12'h342;
  localparam logic [11:0]     CSR_MTVAL  = 12'h343;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(3'd4);

  state_t          r_state;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_target;
  logic            r_flush;
  logic            r_csr_wr_valid;
  logic [11:0]     r_csr_wr_addr;
  logic [XLEN-1:0] r_csr_wr_data;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_irq_cause_ext;
  logic [XLEN-1:0] w_irq_target;
  logic [XLEN-1:0] w_irq_cause_word;
  logic [XLEN-1:0] w_exc_cause_word;
  logic            w_vectored;
  logic            w_csr_fire;
  logic            w_take_irq;

  assign w_base           = {bus.mtvec[XLEN-1:2], 2'b00};
  assign w_vectored       = (bus.mtvec[1:0] == 2'b01);
  assign w_irq_cause_ext  = {{(XLEN-CAUSE_W){1'b0}}, bus.irq_cause};
  // Vector offset wraps modulo 2^XLEN like the PC adder does.
  assign w_irq_target     = w_vectored ? (w_base + (w_irq_cause_ext << 2)) : w_base;
  assign w_irq_cause_word = {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, bus.irq_cause};
  assign w_exc_cause_word = {1'b0, {(XLEN-1-CAUSE_W){1'b0}}, bus.exc_num};
  assign w_csr_fire       = r_csr_wr_valid & bus.csr_wr_ready;
  assign w_take_irq       = bus.irq_pending & bus.irq_enable;

  assign bus.req_ready      = (r_state == S_IDLE);
  assign bus.stall          = (r_state != S_IDLE);
  assign bus.flush          = r_flush;
  assign bus.csr_wr_valid   = r_csr_wr_valid;
  assign bus.csr_wr_addr    = r_csr_wr_addr;
  assign bus.csr_wr_data    = r_csr_wr_data;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;

  // Trap sequencer state, captured trap context and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_cause          <= '0;
      r_tval           <= '0;
      r_target         <= '0;
      r_flush          <= 1'b0;
      r_csr_wr_valid   <= 1'b0;
      r_csr_wr_addr    <= 12'h000;
      r_csr_wr_data    <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.exc_valid) begin
            r_cause        <= w_exc_cause_word;
            r_tval         <= bus.exc_tval;
            r_target       <= w_base;
            r_flush        <= 1'b1;
            r_csr_wr_valid <= 1'b1;
            r_csr_wr_addr  <= CSR_MEPC;
            r_csr_wr_data  <= bus.exc_pc;
            r_state        <= S_WR_EPC;
          end else if (w_take_irq) begin
            r_cause        <= w_irq_cause_word;
            r_tval         <= '0;
            r_target       <= w_irq_target;
            r_flush        <= 1'b1;
            r_csr_wr_valid <= 1'b1;
            r_csr_wr_addr  <= CSR_MEPC;
            r_csr_wr_data  <= bus.irq_pc;
            r_state        <= S_WR_EPC;
          end else if (bus.mret_valid) begin
            r_target         <= bus.mepc;
            r_flush          <= 1'b1;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= bus.mepc;
            r_state          <= S_REDIRECT;
          end else if (bus.wfi_valid) begin
            r_state <= S_WFI_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WR_EPC: begin
          if (w_csr_fire) begin
            r_csr_wr_addr <= CSR_MCAUSE;
            r_csr_wr_data <= r_cause;
            r_state       <= S_WR_CAUSE;
          end else begin
            r_state <= S_WR_EPC;
          end
        end
        S_WR_CAUSE: begin
          if (w_csr_fire) begin
            r_csr_wr_addr <= CSR_MTVAL;
            r_csr_wr_data <= r_tval;
            r_state       <= S_WR_TVAL;
          end else begin
            r_state <= S_WR_CAUSE;
          end
        end
        S_WR_TVAL: begin
          if (w_csr_fire) begin
            r_csr_wr_valid   <= 1'b0;
            r_csr_wr_addr    <= 12'h000;
            r_csr_wr_data    <= '0;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= r_target;
            r_state          <= S_REDIRECT;
          end else begin
            r_state <= S_WR_TVAL;
          end
        end
        S_REDIRECT: begin
          r_state <= S_IDLE;
        end
        S_WFI_WAIT: begin
          // Wake on any pending interrupt; only trap if interrupts are globally enabled.
          if (bus.irq_pending && bus.irq_enable) begin
            r_cause        <= w_irq_cause_word;
            r_tval         <= '0;
            r_target       <= w_irq_target;
            r_csr_wr_valid <= 1'b1;
            r_csr_wr_addr  <= CSR_MEPC;
            r_csr_wr_data  <= bus.wfi_pc + PC_STEP;
            r_state        <= S_WR_EPC;
          end else if (bus.irq_pending) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WFI_WAIT;
          end
        end
        default: begin
          r_csr_wr_valid <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
